// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of a MIPS-style five-stage pipeline. Holds the fetch
// PC, presents it to the instruction memory and forwards the returned
// instruction plus fetch-time exception information to the F/D register.
//
// Next-PC priority (highest first):
//   reset        -> 0x0000_3000 (first instruction of the user program)
//   Req          -> 0x0000_4180 (exception/interrupt handler entry)
//   Stall        -> hold
//   EretD        -> EPC          (eret has no delay slot)
//   BranchTakenD -> BranchTarget (instruction now in F is the delay slot)
//   otherwise    -> PCF + 4      (wraps modulo 2^32)
//
// Ports
//   clk          in   1  clock, all state on the rising edge
//   reset        in   1  synchronous, active-high reset
//   Req          in   1  exception/interrupt taken this cycle
//   Stall        in   1  hazard stall, hold the PC
//   EretD        in   1  eret sits in decode
//   EPC          in  32  eret return address
//   BranchTakenD in   1  branch/jump in decode is taken
//   BranchTarget in  32  target of the taken branch/jump
//   IsBJD        in   1  decode-stage instruction is a branch/jump
//   InstrIn      in  32  instruction memory read data for IAddr
//   IAddr        out 32  instruction memory address (= PCF)
//   PCF          out 32  fetch PC
//   IRF          out 32  fetched instruction (nop when squashed)
//   ExcCodeF     out  5  fetch exception code, 4 = AdEL, 0 = none
//   BDF          out  1  fetched instruction is in a branch delay slot
// -----------------------------------------------------------------------------
module fetch_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic        Stall,
  input  logic        EretD,
  input  logic [31:0] EPC,
  input  logic        BranchTakenD,
  input  logic [31:0] BranchTarget,
  input  logic        IsBJD,
  input  logic [31:0] InstrIn,
  output logic [31:0] IAddr,
  output logic [31:0] PCF,
  output logic [31:0] IRF,
  output logic [4:0]  ExcCodeF,
  output logic        BDF
);

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] IMEM_LO    = 32'h0000_3000;
  localparam logic [31:0] IMEM_HI    = 32'h0000_6FFC;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam logic [4:0]  EXC_NONE   = 5'd0;
  localparam logic [4:0]  EXC_ADEL   = 5'd4;

  // Source of the next fetch PC, resolved by priority.
  typedef enum logic [2:0] {
    SEL_RESET,
    SEL_HANDLER,
    SEL_HOLD,
    SEL_EPC,
    SEL_BRANCH,
    SEL_SEQ
  } pc_sel_e;

  pc_sel_e     pc_sel;
  logic [31:0] pc_d;
  logic [31:0] pc_q;
  logic        addr_misaligned;
  logic        addr_out_of_range;
  logic        fetch_fault;

  // ---------------------------------------------------------------------------
  // Next-PC selection
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default on entry so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    pc_sel = SEL_SEQ;
    if (reset) begin
      pc_sel = SEL_RESET;
    end else if (Req) begin
      pc_sel = SEL_HANDLER;
    end else if (Stall) begin
      pc_sel = SEL_HOLD;
    end else if (EretD) begin
      pc_sel = SEL_EPC;
    end else if (BranchTakenD) begin
      pc_sel = SEL_BRANCH;
    end
  end

  // Redirect targets are loaded without any alignment/range check; a bad
  // address faults as AdEL only once it is the fetch PC.
  always_comb begin
    pc_d = pc_q + 32'd4;
    unique case (pc_sel)
      SEL_RESET:   pc_d = RESET_PC;
      SEL_HANDLER: pc_d = HANDLER_PC;
      SEL_HOLD:    pc_d = pc_q;
      SEL_EPC:     pc_d = EPC;
      SEL_BRANCH:  pc_d = BranchTarget;
      SEL_SEQ:     pc_d = pc_q + 32'd4;
      default:     pc_d = pc_q + 32'd4;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // its pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    pc_q <= pc_d;
  end

  // ---------------------------------------------------------------------------
  // Fetch outputs
  // ---------------------------------------------------------------------------
  assign addr_misaligned   = (pc_q[1:0] != 2'b00);
  assign addr_out_of_range = (pc_q < IMEM_LO) || (pc_q > IMEM_HI);
  assign fetch_fault       = addr_misaligned || addr_out_of_range;

  assign PCF      = pc_q;
  assign IAddr    = pc_q;
  assign ExcCodeF = fetch_fault ? EXC_ADEL : EXC_NONE;

  // The word fetched alongside an eret in decode is squashed (no delay slot),
  // and a faulting fetch never injects real memory data into the pipeline.
  assign IRF = (fetch_fault || EretD) ? NOP_INSTR : InstrIn;

  // Delay-slot flag follows decode even for a faulting fetch, so the EPC
  // logic downstream can still point back at the branch.
  assign BDF = IsBJD;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Drives fetch_stage with directed scenarios followed by randomized control
// traffic. A reference model keeps the architectural fetch PC as a plain
// integer and applies the redirect priority rules; for every cycle the
// expected outputs are pushed into a queue and a separate monitor pops and
// compares them against the DUT on the falling edge.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        Req;
  logic        Stall;
  logic        EretD;
  logic [31:0] EPC;
  logic        BranchTakenD;
  logic [31:0] BranchTarget;
  logic        IsBJD;
  logic [31:0] InstrIn;
  logic [31:0] IAddr;
  logic [31:0] PCF;
  logic [31:0] IRF;
  logic [4:0]  ExcCodeF;
  logic        BDF;

  fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .Req         (Req),
    .Stall       (Stall),
    .EretD       (EretD),
    .EPC         (EPC),
    .BranchTakenD(BranchTakenD),
    .BranchTarget(BranchTarget),
    .IsBJD       (IsBJD),
    .InstrIn     (InstrIn),
    .IAddr       (IAddr),
    .PCF         (PCF),
    .IRF         (IRF),
    .ExcCodeF    (ExcCodeF),
    .BDF         (BDF)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] pcf;
    logic [31:0] irf;
    logic [4:0]  exc;
    logic        bdf;
  } exp_t;

  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  longint      model_pc;   // architectural fetch PC, kept as a wide integer

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Fetchable region is the word-aligned span 0x3000..0x6FFC.
  function automatic bit addr_ok(input longint pc);
    return (pc % 4 == 0) && (pc >= 64'd12288) && (pc <= 64'd28668);
  endfunction

  // One clock cycle: apply inputs, predict outputs from the current model PC,
  // then advance the model PC by the redirect rules at the rising edge.
  task automatic step(input string tag, input bit rst, input bit req, input bit stall,
                      input bit eret, input logic [31:0] epc, input bit bt,
                      input logic [31:0] target, input bit isbj, input logic [31:0] instr);
    exp_t e;
    reset = rst; Req = req; Stall = stall; EretD = eret; EPC = epc;
    BranchTakenD = bt; BranchTarget = target; IsBJD = isbj; InstrIn = instr;
    e.tag = tag;
    e.pcf = model_pc[31:0];
    e.exc = addr_ok(model_pc) ? 5'd0 : 5'd4;
    e.irf = (!addr_ok(model_pc) || eret) ? 32'h0 : instr;
    e.bdf = isbj;
    sb_q.push_back(e);
    @(posedge clk);
    if (rst)        model_pc = 64'h3000;
    else if (req)   model_pc = 64'h4180;
    else if (stall) model_pc = model_pc;
    else if (eret)  model_pc = epc;
    else if (bt)    model_pc = target;
    else            model_pc = (model_pc + 4) % 64'h1_0000_0000;
    #1;
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, $urandom);
  endtask

  // Monitor: compares whatever the stimulus side predicted for this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check({e.tag, ".PCF"},      PCF,             e.pcf);
        check({e.tag, ".IAddr"},    IAddr,           e.pcf);
        check({e.tag, ".IRF"},      IRF,             e.irf);
        check({e.tag, ".ExcCodeF"}, {27'd0, ExcCodeF}, {27'd0, e.exc});
        check({e.tag, ".BDF"},      {31'd0, BDF},    {31'd0, e.bdf});
      end
    end
  end

  initial begin
    logic [31:0] tgt;
    int          pick;
    reset = 1; Req = 0; Stall = 0; EretD = 0; EPC = 0;
    BranchTakenD = 0; BranchTarget = 0; IsBJD = 0; InstrIn = 0;
    @(posedge clk);
    model_pc = 64'h3000;
    #1;

    // Reset state and sequential fetch
    step("reset_state", 0, 0, 0, 0, 32'h0, 0, 32'h0, 1, 32'h1234_5678);
    idle("seq1");
    // Branch at 0x3008 with delay slot flag
    step("branch", 0, 0, 0, 0, 32'h0, 1, 32'h3100, 1, 32'h1111_0000);
    idle("at_target");
    // Stall wins over branch; Req wins over stall
    step("stall_vs_br", 0, 0, 1, 0, 32'h0, 1, 32'h3200, 1, 32'h2222_0000);
    step("stall_vs_req", 0, 1, 1, 0, 32'h0, 1, 32'h3200, 0, 32'h3333_0000);
    idle("at_handler");
    // Eret squashes the fetched word and returns to EPC
    step("eret", 0, 0, 0, 1, 32'h3020, 1, 32'h3300, 0, 32'h4444_0000);
    idle("after_eret");
    // Misaligned branch target faults only one cycle later
    step("br_misalign", 0, 0, 0, 0, 32'h0, 1, 32'h3002, 1, 32'h5555_0000);
    idle("adel_misalign");
    step("br_high", 0, 0, 0, 0, 32'h0, 1, 32'h7000, 0, 32'h6666_0000);
    idle("adel_high");
    step("br_top", 0, 0, 0, 0, 32'h0, 1, 32'h6FFC, 0, 32'h0);
    idle("top_ok");
    idle("past_top");
    step("br_low", 0, 0, 0, 0, 32'h0, 1, 32'h2FFC, 0, 32'h0);
    idle("adel_low");
    // PC+4 wraps with no side effects
    step("br_wrap", 0, 0, 0, 0, 32'h0, 1, 32'hFFFF_FFFC, 0, 32'h0);
    idle("wrap_last");
    idle("wrapped_zero");
    // Reset beats Req and EretD
    step("reset_prio", 1, 1, 0, 1, 32'h3040, 1, 32'h3400, 0, 32'h0);
    idle("after_reset");

    // Randomized traffic; redirects mostly land in the legal region
    for (int i = 0; i < 400; i++) begin
      pick = $urandom_range(0, 9);
      case ($urandom_range(0, 3))
        0:       tgt = $urandom;
        1:       tgt = 32'h3000 + ($urandom_range(0, 16383) & 32'h3FFF);
        default: tgt = 32'h3000 + {$urandom_range(0, 4095), 2'b00};
      endcase
      step("rand", $urandom_range(0, 39) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 5) == 0, pick == 0, tgt, pick < 3,
           tgt ^ {30'd0, 2'($urandom_range(0, 3) == 0)}, $urandom_range(0, 1) == 1,
           $urandom);
    end

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have port Req, input, 1 bit: exception/interrupt taken this cycle; redirect fetch to the handler.
REQ-004 The block SHALL have port Stall, input, 1 bit: hazard stall; hold the PC.
REQ-005 The block SHALL have port EretD, input, 1 bit: eret in the decode stage.
REQ-006 The block SHALL have port EPC, input, 32 bits: return address for eret.
REQ-007 The block SHALL have port BranchTakenD, input, 1 bit: branch/jump in decode is taken.
REQ-008 The block SHALL have port BranchTarget, input, 32 bits: target of the taken branch/jump.
REQ-009 The block SHALL have port IsBJD, input, 1 bit: the decode-stage instruction is a branch or jump.
REQ-010 The block SHALL have port InstrIn, input, 32 bits: instruction word returned by the instruction memory for IAddr.
REQ-011 The block SHALL have port IAddr, output, 32 bits: instruction memory address, equal to PCF.
REQ-012 The block SHALL have port PCF, output, 32 bits: fetch PC, feeding the F/D register.
REQ-013 The block SHALL have port IRF, output, 32 bits: fetched instruction, feeding the F/D register.
REQ-014 The block SHALL have port ExcCodeF, output, 5 bits: fetch exception code; 0 means none.
REQ-015 The block SHALL have port BDF, output, 1 bit: the fetched instruction sits in a branch delay slot.

Function
REQ-016 PCF SHALL be a 32-bit register updated every rising clk edge by this priority: reset, then Req, then Stall, then EretD, then BranchTakenD, then PCF+4.
REQ-017 Req=1 SHALL load PCF=0x0000_4180 regardless of Stall, EretD and BranchTakenD.
REQ-018 Stall=1 with Req=0 SHALL hold PCF unchanged; the EretD and branch inputs are ignored that cycle.
REQ-019 EretD=1 (no Req, no Stall) SHALL load PCF=EPC; eret has no delay slot.
REQ-020 BranchTakenD=1 (no Req, Stall or EretD) SHALL load PCF=BranchTarget; the instruction currently in F executes as the delay slot.
REQ-021 PCF+4 SHALL wrap modulo 2^32, with no overflow flag.
REQ-022 IAddr SHALL equal PCF combinationally.
REQ-023 ExcCodeF SHALL be 5'd4 (AdEL) combinationally when PCF[1:0]!=0 or PCF is outside 0x0000_3000..0x0000_6FFC inclusive; otherwise it SHALL be 0.
REQ-024 IRF SHALL be 0 (nop) when ExcCodeF!=0 or EretD=1; otherwise IRF SHALL equal InstrIn.
REQ-025 BDF SHALL equal IsBJD combinationally, including when ExcCodeF!=0.
REQ-026 A misaligned or out-of-range EPC or BranchTarget SHALL still be loaded into PCF; the fault SHALL surface as AdEL in the following cycle and not earlier.

Reset
REQ-027 On a rising edge with reset=1, PCF SHALL become 0x0000_3000, regardless of every other input.
REQ-028 With PCF=0x3000 after reset, ExcCodeF SHALL be 0, BDF SHALL follow IsBJD and IRF SHALL follow InstrIn.
REQ-029 Reset SHALL take effect mid-operation; an in-flight Req, EretD or branch in the same cycle SHALL be discarded.

Verification
REQ-030 Sequential fetch: reset, then 3 cycles with no control -> PCF = 0x3000, 0x3004, 0x3008, 0x300C.
REQ-031 Branch with delay slot: at PCF=0x3004, BranchTakenD=1, BranchTarget=0x3100, IsBJD=1 -> BDF=1 that cycle; next cycle PCF=0x3100.
REQ-032 Stall against redirects: Stall=1 with BranchTakenD=1 -> PCF held; Stall=1 with Req=1 -> PCF=0x4180 next cycle.
REQ-033 Eret: EretD=1, EPC=0x3020 -> IRF=0 that cycle; next cycle PCF=0x3020.
REQ-034 AdEL: BranchTarget=0x3002 taken -> next cycle ExcCodeF=4 and IRF=0; BranchTarget=0x7000 -> ExcCodeF=4; a PCF of 0x6FFC gives ExcCodeF=0.
REQ-035 Reset priority: reset=1 together with Req=1 and EretD=1 -> PCF=0x3000 next cycle.
